// File: rtl/memory_mb_pkg.sv
// Shared types and helpers for the banked memory read path.
// The tag struct records which requestor owns the read currently in flight in a bank.
package memory_mb_pkg;

    localparam int pkg_num_ports = 4;
    localparam int port_bits     = $clog2(pkg_num_ports);

    typedef struct packed {
        logic                 valid;
        logic [port_bits-1:0] port;
    } bank_tag_t;

    function automatic int addr_bit_width_f(input int entries);
        return $clog2(entries);
    endfunction

    function automatic int bank_bits_f(input int banks);
        return $clog2(banks);
    endfunction

endpackage

// File: rtl/memory_mb_rd_router_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, scanning upward mod N.
// Emits a one-hot grant, the granted index and a grant-present flag.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < N; i++) begin : scan
            int c;
            c = (int'(ptr) + i) % N;
            if (!any && req[c]) begin
                any      = 1'b1;
                grant[c] = 1'b1;
                idx      = IW'(c);
            end
        end
    end

endmodule

// File: rtl/memory_mb_rd_router.sv
// Routes flat-address read requests from several ports onto interleaved banks,
// arbitrates each bank round-robin and returns read data with a fixed 2-cycle latency.
module memory_mb_rd_router
    import memory_mb_pkg::*;
#(
    parameter int num_ports        = pkg_num_ports,
    parameter int num_banks        = 4,
    parameter int num_bank_entries = 8,
    parameter int bit_width        = 32,
    parameter int cnt_width        = 16,
    parameter int addr_bit_width   = addr_bit_width_f(num_bank_entries),
    parameter int bank_bits        = bank_bits_f(num_banks),
    parameter int flat_addr_width  = addr_bit_width + bank_bits
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [num_ports-1:0]                 req_valid,
    input  logic [num_ports*flat_addr_width-1:0] req_addr,
    output logic [num_ports-1:0]                 req_ready,
    output logic [num_ports-1:0]                 resp_valid,
    output logic [num_ports*bit_width-1:0]       resp_data,
    output logic [num_banks-1:0]                 rd_en,
    output logic [num_banks*addr_bit_width-1:0]  rd_addr,
    input  logic [num_banks*bit_width-1:0]       rd_data,
    output logic [cnt_width-1:0]                 conflict_cnt
);

    localparam int pw = (num_ports > 1) ? $clog2(num_ports) : 1;

    logic [num_ports-1:0]           cand    [num_banks];
    logic [num_ports-1:0]           grant   [num_banks];
    logic [pw-1:0]                  win_idx [num_banks];
    logic [num_banks-1:0]           win_any;
    logic [pw-1:0]                  rr_ptr_q [num_banks];
    logic [pw-1:0]                  rr_ptr_d [num_banks];
    bank_tag_t                      tag_q    [num_banks];
    bank_tag_t                      tag_d    [num_banks];
    logic [num_ports-1:0]           resp_valid_q, resp_valid_d;
    logic [num_ports*bit_width-1:0] resp_data_q, resp_data_d;
    logic [cnt_width-1:0]           conflict_cnt_q, conflict_cnt_d;
    logic [cnt_width:0]             cnt_sum;
    int                             n_conf;

    // Candidates are masked during reset so no grant or memory read can start.
    always_comb begin
        for (int b = 0; b < num_banks; b++) begin
            cand[b] = '0;
            for (int p = 0; p < num_ports; p++) begin
                if (req_valid[p] && !rst &&
                    req_addr[p*flat_addr_width +: bank_bits] == bank_bits'(b))
                    cand[b][p] = 1'b1;
            end
        end
    end

    for (genvar gb = 0; gb < num_banks; gb++) begin : g_bank
        rr_arbiter #(.N(num_ports), .IW(pw)) u_arb (
            .req   (cand[gb]),
            .ptr   (rr_ptr_q[gb]),
            .grant (grant[gb]),
            .idx   (win_idx[gb]),
            .any   (win_any[gb])
        );
    end

    always_comb begin
        req_ready    = '0;
        rd_en        = '0;
        rd_addr      = '0;
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        n_conf       = 0;
        for (int b = 0; b < num_banks; b++) begin
            req_ready = req_ready | grant[b];
            rd_en[b]  = win_any[b];
            if (win_any[b])
                rd_addr[b*addr_bit_width +: addr_bit_width] =
                    req_addr[int'(win_idx[b])*flat_addr_width + bank_bits +: addr_bit_width];
            if (win_any[b])
                rr_ptr_d[b] = (win_idx[b] == pw'(num_ports-1)) ? '0 : win_idx[b] + 1'b1;
            else
                rr_ptr_d[b] = rr_ptr_q[b];
            tag_d[b].valid = win_any[b];
            tag_d[b].port  = port_bits'(win_idx[b]);
            // The read issued last cycle has its data on rd_data now.
            if (tag_q[b].valid) begin
                resp_valid_d[tag_q[b].port] = 1'b1;
                resp_data_d[int'(tag_q[b].port)*bit_width +: bit_width] =
                    rd_data[b*bit_width +: bit_width];
            end
            if ($countones(cand[b]) >= 2)
                n_conf = n_conf + 1;
        end
        cnt_sum        = {1'b0, conflict_cnt_q} + (cnt_width+1)'(n_conf);
        conflict_cnt_d = cnt_sum[cnt_width] ? '1 : cnt_sum[cnt_width-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q   <= '0;
            resp_data_q    <= '0;
            conflict_cnt_q <= '0;
            for (int b = 0; b < num_banks; b++) begin
                rr_ptr_q[b] <= '0;
                tag_q[b]    <= '0;
            end
        end else begin
            resp_valid_q   <= resp_valid_d;
            resp_data_q    <= resp_data_d;
            conflict_cnt_q <= conflict_cnt_d;
            for (int b = 0; b < num_banks; b++) begin
                rr_ptr_q[b] <= rr_ptr_d[b];
                tag_q[b]    <= tag_d[b];
            end
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_data    = resp_data_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_memory_mb_rd_router.sv
// Directed bench for memory_mb_rd_router with a behavioural bank memory holding value a at flat address a.
// A second instance with a 4-bit counter shares the stimulus to exercise saturation.
module tb_memory_mb_rd_router;

    localparam int NP  = 4;
    localparam int NB  = 4;
    localparam int BW  = 32;
    localparam int AW  = 3;
    localparam int FAW = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NP-1:0]   req_valid = '0;
    logic [NP*FAW-1:0] req_addr = '0;
    logic [NP-1:0]   req_ready, resp_valid;
    logic [NP*BW-1:0] resp_data;
    logic [NB-1:0]   rd_en;
    logic [NB*AW-1:0] rd_addr;
    logic [NB*BW-1:0] rd_data = '0;
    logic [15:0]     conflict_cnt;

    logic [NP-1:0]   s_req_ready, s_resp_valid;
    logic [NP*BW-1:0] s_resp_data;
    logic [NB-1:0]   s_rd_en;
    logic [NB*AW-1:0] s_rd_addr;
    logic [3:0]      s_conflict_cnt;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [BW-1:0] exp_q [NP][$];
    int            cyc_q [NP][$];

    logic        chk_rdy = 1'b0;
    logic [3:0]  exp_rdy = '0;
    logic        chk_cnt = 1'b0;
    logic [15:0] exp_cnt = '0;
    logic        chk_sat = 1'b0;
    logic [3:0]  exp_sat = '0;
    int          chk_rst = 0;

    memory_mb_rd_router dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .conflict_cnt(conflict_cnt)
    );

    memory_mb_rd_router #(.cnt_width(4)) dut_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(s_req_ready), .resp_valid(s_resp_valid), .resp_data(s_resp_data),
        .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(rd_data), .conflict_cnt(s_conflict_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // bank memory: bank b, row r holds 4r+b, one-cycle read latency
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++)
            if (rd_en[b])
                rd_data[b*BW +: BW] <= BW'(rd_addr[b*AW +: AW]) * 4 + BW'(b);
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        if (chk_rdy) begin
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL req_ready cyc=%0d got=%b want=%b", cyc, req_ready, exp_rdy);
            end
        end
        if (chk_cnt) begin
            checks++;
            if (conflict_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL conflict_cnt cyc=%0d got=%0d want=%0d", cyc, conflict_cnt, exp_cnt);
            end
        end
        if (chk_sat) begin
            checks++;
            if (s_conflict_cnt !== exp_sat) begin
                errors++;
                $display("FAIL conflict_cnt_sat cyc=%0d got=%0d want=%0d", cyc, s_conflict_cnt, exp_sat);
            end
        end
        if (chk_rst >= 1) begin
            checks++;
            if (req_ready !== '0 || rd_en !== '0) begin
                errors++;
                $display("FAIL reset_gate cyc=%0d req_ready=%b rd_en=%b want 0", cyc, req_ready, rd_en);
            end
        end
        if (chk_rst >= 2) begin
            checks++;
            if (resp_valid !== '0 || resp_data !== '0 || conflict_cnt !== '0) begin
                errors++;
                $display("FAIL reset_regs cyc=%0d resp_valid=%b cnt=%0d want 0", cyc, resp_valid, conflict_cnt);
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (resp_valid[p]) begin
                checks++;
                if (exp_q[p].size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected port=%0d cyc=%0d data=%0d", p, cyc, resp_data[p*BW +: BW]);
                end else begin
                    logic [BW-1:0] d;
                    int c;
                    d = exp_q[p].pop_front();
                    c = cyc_q[p].pop_front();
                    if (resp_data[p*BW +: BW] !== d || cyc != c) begin
                        errors++;
                        $display("FAIL resp port=%0d got data=%0d cyc=%0d want data=%0d cyc=%0d",
                                 p, resp_data[p*BW +: BW], cyc, d, c);
                    end
                end
            end else if (cyc_q[p].size() > 0 && cyc_q[p][0] <= cyc) begin
                logic [BW-1:0] d;
                int c;
                checks++;
                errors++;
                d = exp_q[p].pop_front();
                c = cyc_q[p].pop_front();
                $display("FAIL resp_missing port=%0d got none want data=%0d at cyc=%0d", p, d, c);
            end
        end
    end

    // driver tasks
    task automatic step(input logic [3:0] v, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [4:0] a3,
                        input logic [3:0] rdy, input logic push);
        logic [4:0] a [NP];
        a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
        req_valid = v;
        req_addr  = {a3, a2, a1, a0};
        chk_rdy   = 1'b1;
        exp_rdy   = rdy;
        if (push)
            for (int p = 0; p < NP; p++)
                if (rdy[p]) begin
                    exp_q[p].push_back(BW'(a[p]));
                    cyc_q[p].push_back(cyc + 2);
                end
        @(negedge clk);
        @(posedge clk);
        #1;
        chk_rdy = 1'b0;
        chk_cnt = 1'b0;
        chk_sat = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'h0, 0, 0, 0, 0, 4'h0, 1'b0);
    endtask

    task automatic check_cnt(input logic [15:0] c, input logic do_sat, input logic [3:0] s);
        chk_cnt = 1'b1;
        exp_cnt = c;
        chk_sat = do_sat;
        exp_sat = s;
        idle(1);
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        req_valid = 4'hF;
        req_addr  = {5'd3, 5'd2, 5'd1, 5'd0};
        for (int i = 0; i < n; i++) begin
            chk_rst = (i == 0) ? 1 : 2;
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        chk_rst   = 0;
        rst       = 1'b0;
        req_valid = '0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset(3);
        check_cnt(16'd0, 1'b1, 4'd0);

        // conflict-free: one port per bank
        step(4'hF, 0, 1, 2, 3, 4'hF, 1'b1);
        idle(3);
        check_cnt(16'd0, 1'b0, 4'd0);

        // full conflict on bank 0, requestors hold until granted
        idle(2);
        do_reset(2);
        step(4'hF, 0, 4, 8, 12, 4'b0001, 1'b1);
        step(4'hE, 0, 4, 8, 12, 4'b0010, 1'b1);
        step(4'hC, 0, 4, 8, 12, 4'b0100, 1'b1);
        step(4'h8, 0, 4, 8, 12, 4'b1000, 1'b1);
        idle(2);
        check_cnt(16'd3, 1'b1, 4'd3);

        // fairness: ports 0 and 2 on bank 1
        do_reset(2);
        for (int i = 0; i < 6; i++)
            step(4'b0101, 1, 0, 5, 0, (i % 2 == 0) ? 4'b0001 : 4'b0100, 1'b1);
        idle(2);
        check_cnt(16'd6, 1'b0, 4'd0);

        // streaming: port 1, addresses 5..20 back-to-back
        do_reset(2);
        for (int i = 0; i < 16; i++)
            step(4'b0010, 0, 5'(5 + i), 0, 0, 4'b0010, 1'b1);
        idle(3);
        check_cnt(16'd0, 1'b0, 4'd0);

        // reset right after an accepted request discards it and the rr pointer
        step(4'b0010, 0, 4, 0, 0, 4'b0010, 1'b0);
        do_reset(1);
        check_cnt(16'd0, 1'b1, 4'd0);
        idle(2);
        step(4'hF, 0, 4, 8, 12, 4'b0001, 1'b1);
        idle(3);

        // saturation: all ports contend on bank 0 for 20 cycles
        do_reset(2);
        for (int i = 0; i < 20; i++)
            step(4'hF, 0, 4, 8, 12, 4'(1 << (i % 4)), 1'b1);
        idle(2);
        check_cnt(16'd20, 1'b1, 4'd15);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
